writeback_stage: RTL and testbench

Dual-lane memory-to-writeback pipeline stage that sits directly downstream of the memory stage. Each cycle it registers the two lane results (ResultA, ResultB) together with their destination registers and write enables. It resolves same-destination conflicts between the lanes and drives the two register-file write ports. It also provides the WB-to-decode bypass of those writes and, optionally, a retired-instruction counter.

---
 rtl/writeback_stage.sv | 91 +++++++++
 tb/tb_writeback_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - dual-lane writeback stage with RF write ports, WB bypass and optional retire counter (RETIRE_CNT_EN)
module writeback_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] ResultA,
  input  logic [DATA_WIDTH-1:0] ResultB,
  input  logic [ADDR_WIDTH-1:0] RdA,
  input  logic [ADDR_WIDTH-1:0] RdB,
  input  logic                  RegWriteA,
  input  logic                  RegWriteB,
  input  logic                  ValidA,
  input  logic                  ValidB,
  output logic                  WE3A,
  output logic                  WE3B,
  output logic [ADDR_WIDTH-1:0] A3A,
  output logic [ADDR_WIDTH-1:0] A3B,
  output logic [DATA_WIDTH-1:0] WD3A,
  output logic [DATA_WIDTH-1:0] WD3B,
  input  logic [ADDR_WIDTH-1:0] RsAddr [4],
  input  logic [DATA_WIDTH-1:0] RsData [4],
  output logic [DATA_WIDTH-1:0] RsFwd  [4],
  output logic [CNT_WIDTH-1:0]  retire_count
);

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] result;
  } lane_t;

  lane_t a_q, b_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      a_q <= '0;
      b_q <= '0;
    end else if (!stall) begin
      a_q <= '{valid: ValidA, regwrite: RegWriteA, rd: RdA, result: ResultA};
      b_q <= '{valid: ValidB, regwrite: RegWriteB, rd: RdB, result: ResultB};
    end
  end

  logic raw_we_a, raw_we_b;

  assign raw_we_a = a_q.valid && a_q.regwrite && (a_q.rd != '0);
  assign raw_we_b = b_q.valid && b_q.regwrite && (b_q.rd != '0);

  // lane B is the younger instruction, so it owns a shared destination
  assign WE3A = raw_we_a && !(raw_we_b && (a_q.rd == b_q.rd));
  assign WE3B = raw_we_b;
  assign A3A  = a_q.rd;
  assign A3B  = b_q.rd;
  assign WD3A = a_q.result;
  assign WD3B = b_q.result;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      RsFwd[i] = RsData[i];
      if (RsAddr[i] == '0)
        RsFwd[i] = '0;
      else if (WE3B && (A3B == RsAddr[i]))
        RsFwd[i] = WD3B;
      else if (WE3A && (A3A == RsAddr[i]))
        RsFwd[i] = WD3A;
    end
  end

`ifdef RETIRE_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  // stalled cycles are skipped so a held bundle is counted exactly once
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (!stall)
      cnt_q <= cnt_q + CNT_WIDTH'(a_q.valid) + CNT_WIDTH'(b_q.valid);
  end

  assign retire_count = cnt_q;
`else
  assign retire_count = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - scoreboard bench for writeback_stage (4-bit retire counter, RETIRE_CNT_EN aware)
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [31:0] res_a, res_b;
  logic [4:0]  rd_a, rd_b;
  logic        rw_a, rw_b, v_a, v_b;
  logic        we3a, we3b;
  logic [4:0]  a3a, a3b;
  logic [31:0] wd3a, wd3b;
  logic [4:0]  rs_addr [4];
  logic [31:0] rs_data [4];
  logic [31:0] rs_fwd  [4];
  logic [3:0]  retire_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  writeback_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ResultA(res_a), .ResultB(res_b), .RdA(rd_a), .RdB(rd_b),
    .RegWriteA(rw_a), .RegWriteB(rw_b), .ValidA(v_a), .ValidB(v_b),
    .WE3A(we3a), .WE3B(we3b), .A3A(a3a), .A3B(a3b), .WD3A(wd3a), .WD3B(wd3b),
    .RsAddr(rs_addr), .RsData(rs_data), .RsFwd(rs_fwd),
    .retire_count(retire_count)
  );

  // reference model of the stage register and counter
  logic        m_va, m_vb, m_wa, m_wb;
  logic [4:0]  m_rda, m_rdb;
  logic [31:0] m_resa, m_resb;
  logic [3:0]  m_cnt;

  typedef struct {
    logic        we3a, we3b;
    logic [4:0]  a3a, a3b;
    logic [31:0] wd3a, wd3b;
    logic [3:0]  cnt;
  } exp_t;

  exp_t sbq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic mwe_b();
    return m_vb && m_wb && (m_rdb != 5'd0);
  endfunction

  function automatic logic mwe_a();
    return m_va && m_wa && (m_rda != 5'd0) && !(mwe_b() && m_rda == m_rdb);
  endfunction

  function automatic logic [31:0] mbyp(input logic [4:0] addr, input logic [31:0] data);
    if (addr == 5'd0) return 32'd0;
    if (mwe_b() && m_rdb == addr) return m_resb;
    if (mwe_a() && m_rda == addr) return m_resa;
    return data;
  endfunction

  task automatic cycle(input bit r, input bit s, input bit f,
                       input bit va, input bit wa, input logic [4:0] ra, input logic [31:0] da,
                       input bit vb, input bit wb, input logic [4:0] rb, input logic [31:0] db);
    exp_t e, o;
    rst = r; stall = s; flush = f;
    v_a = va; rw_a = wa; rd_a = ra; res_a = da;
    v_b = vb; rw_b = wb; rd_b = rb; res_b = db;
    if (r) m_cnt = 4'd0;
    else if (!s) m_cnt = m_cnt + 4'(m_va) + 4'(m_vb);
    if (r || f) begin
      m_va = 0; m_wa = 0; m_rda = 0; m_resa = 0;
      m_vb = 0; m_wb = 0; m_rdb = 0; m_resb = 0;
    end else if (!s) begin
      m_va = va; m_wa = wa; m_rda = ra; m_resa = da;
      m_vb = vb; m_wb = wb; m_rdb = rb; m_resb = db;
    end
    e.we3a = mwe_a(); e.we3b = mwe_b();
    e.a3a = m_rda; e.a3b = m_rdb; e.wd3a = m_resa; e.wd3b = m_resb;
`ifdef RETIRE_CNT_EN
    e.cnt = m_cnt;
`else
    e.cnt = 4'd0;
`endif
    sbq.push_back(e);
    @(posedge clk);
    #1;
    o = sbq.pop_front();
    check("we3a", 64'(we3a), 64'(o.we3a));
    check("we3b", 64'(we3b), 64'(o.we3b));
    check("a3a", 64'(a3a), 64'(o.a3a));
    check("a3b", 64'(a3b), 64'(o.a3b));
    check("wd3a", 64'(wd3a), 64'(o.wd3a));
    check("wd3b", 64'(wd3b), 64'(o.wd3b));
    check("retire_count", 64'(retire_count), 64'(o.cnt));
  endtask

  task automatic bubble();
    cycle(0, 0, 0, 0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
  endtask

  task automatic check_bypass_model();
    for (int i = 0; i < 4; i++) begin
      rs_addr[i] = 5'($urandom_range(0, 7));
      rs_data[i] = $urandom;
    end
    #1;
    for (int i = 0; i < 4; i++)
      check("rsfwd_model", 64'(rs_fwd[i]), 64'(mbyp(rs_addr[i], rs_data[i])));
  endtask

  function automatic logic [3:0] exp_cnt(input logic [3:0] v);
`ifdef RETIRE_CNT_EN
    return v;
`else
    return 4'd0 & v;
`endif
  endfunction

  initial begin
    logic [3:0] c0;
    m_cnt = 0;
    m_va = 0; m_vb = 0; m_wa = 0; m_wb = 0;
    m_rda = 0; m_rdb = 0; m_resa = 0; m_resb = 0;
    for (int i = 0; i < 4; i++) begin
      rs_addr[i] = 5'd0;
      rs_data[i] = 32'd0;
    end

    // reset held two cycles with random inputs
    for (int k = 0; k < 2; k++) begin
      cycle(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom,
            1'($urandom), 1'($urandom), 5'($urandom), $urandom);
      check("rst_we3a", 64'(we3a), 64'd0);
      check("rst_count", 64'(retire_count), 64'd0);
    end
    rs_addr[0] = 5'd0; rs_data[0] = 32'h5555_aaaa;
    rs_addr[1] = 5'd3; rs_data[1] = 32'h0000_1234;
    #1;
    check("rst_fwd_x0", 64'(rs_fwd[0]), 64'd0);
    check("rst_fwd_pass", 64'(rs_fwd[1]), 64'h1234);

    // basic capture
    cycle(0, 0, 0, 1, 1, 5'd5, 32'hDEADBEEF, 1, 1, 5'd6, 32'h12345678);
    check("cap_we3a", 64'(we3a), 64'd1);
    check("cap_we3b", 64'(we3b), 64'd1);
    check("cap_wd3a", 64'(wd3a), 64'hDEADBEEF);
    check("cap_a3b", 64'(a3b), 64'd6);
    c0 = retire_count;
    bubble();
    check("cap_count_plus2", 64'(retire_count), 64'(exp_cnt(c0 + 4'd2)));

    // same destination conflict, then x0
    cycle(0, 0, 0, 1, 1, 5'd7, 32'h1111_0000, 1, 1, 5'd7, 32'h2222_0000);
    check("conf_we3a", 64'(we3a), 64'd0);
    check("conf_we3b", 64'(we3b), 64'd1);
    check("conf_wd3b", 64'(wd3b), 64'h2222_0000);
    cycle(0, 0, 0, 1, 1, 5'd0, 32'h3333_0000, 0, 1, 5'd4, 32'h4444_0000);
    check("x0_we3a", 64'(we3a), 64'd0);

    // three-cycle stall
    cycle(0, 0, 0, 1, 1, 5'd9, 32'h9999_0001, 1, 0, 5'd10, 32'hAAAA_0002);
    c0 = retire_count;
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, 1, 1, 5'd11, 32'hBAD0_0000, 1, 1, 5'd12, 32'hBAD1_0000);
      check("stall_hold_a3a", 64'(a3a), 64'd9);
      check("stall_count", 64'(retire_count), 64'(c0));
    end
    bubble();
    check("stall_release_count", 64'(retire_count), 64'(exp_cnt(c0 + 4'd2)));

    // flush, then flush with stall
    cycle(0, 0, 1, 1, 1, 5'd13, 32'hF00D_0000, 1, 1, 5'd14, 32'hF00D_0001);
    check("flush_we3a", 64'(we3a), 64'd0);
    check("flush_we3b", 64'(we3b), 64'd0);
    c0 = retire_count;
    cycle(0, 0, 0, 1, 1, 5'd15, 32'h1500_0000, 1, 1, 5'd16, 32'h1600_0000);
    check("flush_adds0", 64'(retire_count), 64'(c0));
    c0 = retire_count;
    cycle(0, 1, 1, 1, 1, 5'd17, 32'h1700_0000, 1, 1, 5'd18, 32'h1800_0000);
    check("sf_we3b", 64'(we3b), 64'd0);
    check("sf_count", 64'(retire_count), 64'(c0));

    // bypass with lane B winning x5
    cycle(0, 0, 0, 1, 1, 5'd5, 32'hAA, 1, 1, 5'd5, 32'hBB);
    rs_addr[0] = 5'd5; rs_addr[1] = 5'd0; rs_addr[2] = 5'd9; rs_addr[3] = 5'd5;
    for (int i = 0; i < 4; i++) rs_data[i] = 32'hC0DE_0000 + 32'(i);
    #1;
    check("byp0", 64'(rs_fwd[0]), 64'hBB);
    check("byp1", 64'(rs_fwd[1]), 64'd0);
    check("byp2", 64'(rs_fwd[2]), 64'hC0DE_0002);
    check("byp3", 64'(rs_fwd[3]), 64'hBB);

    // randomised traffic with small register range to provoke conflicts
    for (int k = 0; k < 60; k++) begin
      cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), $urandom,
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      check_bypass_model();
    end

    // counter wrap 0xE -> 0x0 -> 0x2
    cycle(1, 0, 0, 0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
    for (int k = 0; k < 16 && retire_count != exp_cnt(4'hE); k++)
      cycle(0, 0, 0, 1, 0, 5'd1, 32'd1, 1, 0, 5'd2, 32'd2);
    check("wrap_e", 64'(retire_count), 64'(exp_cnt(4'hE)));
    cycle(0, 0, 0, 1, 0, 5'd1, 32'd1, 1, 0, 5'd2, 32'd2);
    check("wrap_0", 64'(retire_count), 64'd0);
    cycle(0, 0, 0, 1, 0, 5'd1, 32'd1, 1, 0, 5'd2, 32'd2);
    check("wrap_2", 64'(retire_count), 64'(exp_cnt(4'h2)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
